// File: rtl/iir_pkg.sv
// iir_pkg: shared definitions for the IIR filter / decimator chain.
//   - default data format (Ndint integer bits incl. sign, Ndfrac fractional bits)
//   - signed data word type for the default format
//   - decimator phase state encoding
//   - acc_width(): accumulator width that cannot overflow while summing
//     up to 2^lmax data words
package iir_pkg;

  localparam int NDINT_DEF  = 3;
  localparam int NDFRAC_DEF = 22;
  localparam int LMAX_DEF   = 4;

  typedef logic signed [NDINT_DEF+NDFRAC_DEF-1:0] data_t;

  // state | meaning
  // ------+---------------------------------------------
  // IDLE  | phase == 0, waiting for first sample of a group
  // ACCUM | phase  > 0, group in progress
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } phase_state_e;

  function automatic int acc_width(input int ndint, input int ndfrac, input int lmax);
    return ndint + ndfrac + lmax;
  endfunction

endpackage

// File: rtl/iir_rshift_round.sv
// iir_rshift_round: combinational arithmetic right shift by 0..2^SW-1 with
// round-half-up (toward +inf), result truncated to OW bits.
//   x_i  [IW-1:0] signed input
//   sh_i [SW-1:0] shift amount
//   y_o  [OW-1:0] (x_i + 2^(sh_i-1)) >>> sh_i, low OW bits
// The caller guarantees the shifted value fits in OW bits.
module iir_rshift_round #(
  parameter int IW = 29,
  parameter int OW = 25,
  parameter int SW = 3
) (
  input  logic signed [IW-1:0] x_i,
  input  logic        [SW-1:0] sh_i,
  output logic signed [OW-1:0] y_o
);

  logic signed [IW:0] rnd;
  logic signed [IW:0] biased;
  logic signed [IW:0] shifted;
  logic               unused_hi;

  // One guard bit so adding the rounding constant can never wrap.
  always_comb begin
    rnd = '0;
    if (sh_i != '0) begin
      rnd = (IW+1)'(1) << (sh_i - SW'(1));
    end
    biased  = $signed({x_i[IW-1], x_i}) + rnd;
    shifted = biased >>> sh_i;
  end

  assign y_o       = shifted[OW-1:0];
  assign unused_hi = ^shifted[IW:OW];

endmodule

// File: rtl/iir_decim.sv
// iir_decim: decimate an iir_sos sample stream by R = 2^ratio_log2.
//   mode 0 = pick (first sample of each group), 1 = average (sum, /R, rounded).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   sync_in              (only with IIR_DECIM_SYNC_EN) drop partial group
//   dv_in, d_in          input strobe and signed sample [Ndint-1:-Ndfrac]
//   ratio_log2, mode     latched at each group start; ratio clamped to Lmax
//   dv_out, d_out        one-cycle output strobe, sample held between strobes
// Optional feature macro: IIR_DECIM_SYNC_EN.
module iir_decim
  import iir_pkg::*;
#(
  parameter int Ndint  = NDINT_DEF,
  parameter int Ndfrac = NDFRAC_DEF,
  parameter int Lmax   = LMAX_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
`ifdef IIR_DECIM_SYNC_EN
  input  logic                               sync_in,
`endif
  input  logic                               dv_in,
  input  logic signed [Ndint-1:-Ndfrac]      d_in,
  input  logic        [$clog2(Lmax+1)-1:0]   ratio_log2,
  input  logic                               mode,
  output logic                               dv_out,
  output logic signed [Ndint-1:-Ndfrac]      d_out
);

  localparam int DW = Ndint + Ndfrac;
  localparam int AW = acc_width(Ndint, Ndfrac, Lmax);
  localparam int RW = $clog2(Lmax + 1);
  localparam int PW = Lmax;

  logic [PW-1:0]        phase_q, phase_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [RW-1:0]        ratio_q, ratio_d;
  logic                 mode_q, mode_d;
  logic signed [DW-1:0] cand_q, cand_d;
  logic                 dv_out_q, dv_out_d;
  logic signed [DW-1:0] d_out_q, d_out_d;

  phase_state_e         state;
  logic                 group_start;
  logic [RW-1:0]        ratio_clamped;
  logic [RW-1:0]        ratio_use;
  logic                 mode_use;
  logic [PW-1:0]        phase_use;
  logic signed [DW-1:0] cand_use;
  logic signed [AW-1:0] d_ext;
  logic signed [AW-1:0] acc_sum;
  logic [PW:0]          r_last;
  logic signed [DW-1:0] avg_val;

  assign state         = (phase_q == '0) ? ST_IDLE : ST_ACCUM;
  assign ratio_clamped = (ratio_log2 > RW'(Lmax)) ? RW'(Lmax) : ratio_log2;
  assign d_ext         = {{(AW-DW){d_in[Ndint-1]}}, d_in};

  // Operands for this cycle: a group start (or a sync restart) takes ratio,
  // mode and the first sample straight from the inputs.
  always_comb begin
    group_start = (state == ST_IDLE);
`ifdef IIR_DECIM_SYNC_EN
    if (sync_in) group_start = 1'b1;
`endif
    if (group_start) begin
      ratio_use = ratio_clamped;
      mode_use  = mode;
      phase_use = '0;
      cand_use  = d_in;
      acc_sum   = d_ext;
    end else begin
      ratio_use = ratio_q;
      mode_use  = mode_q;
      phase_use = phase_q;
      cand_use  = cand_q;
      acc_sum   = acc_q + d_ext;
    end
    r_last = ({{PW{1'b0}}, 1'b1} << ratio_use) - 1'b1;
  end

  iir_rshift_round #(
    .IW (AW),
    .OW (DW),
    .SW (RW)
  ) u_round (
    .x_i  (acc_sum),
    .sh_i (ratio_use),
    .y_o  (avg_val)
  );

  always_comb begin
    phase_d  = phase_q;
    acc_d    = acc_q;
    ratio_d  = ratio_q;
    mode_d   = mode_q;
    cand_d   = cand_q;
    dv_out_d = 1'b0;
    d_out_d  = d_out_q;
`ifdef IIR_DECIM_SYNC_EN
    if (sync_in) begin
      phase_d = '0;
      acc_d   = '0;
    end
`endif
    if (dv_in) begin
      if (group_start) begin
        ratio_d = ratio_clamped;
        mode_d  = mode;
        cand_d  = d_in;
      end
      if ({1'b0, phase_use} == r_last) begin
        phase_d  = '0;
        acc_d    = '0;
        dv_out_d = 1'b1;
        d_out_d  = mode_use ? avg_val : cand_use;
      end else begin
        phase_d = phase_use + PW'(1);
        acc_d   = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= '0;
      acc_q    <= '0;
      ratio_q  <= '0;
      mode_q   <= 1'b0;
      cand_q   <= '0;
      dv_out_q <= 1'b0;
      d_out_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      ratio_q  <= ratio_d;
      mode_q   <= mode_d;
      cand_q   <= cand_d;
      dv_out_q <= dv_out_d;
      d_out_q  <= d_out_d;
    end
  end

  assign dv_out = dv_out_q;
  assign d_out  = d_out_q;

endmodule

// File: tb/tb_iir_decim.sv
// tb_iir_decim: directed vectors for iir_decim with a scoreboard queue.
// Stimulus pushes the expected sample and the cycle it must appear in;
// an independent monitor pops and compares on every dv_out.
module tb_iir_decim;
  import iir_pkg::*;

  localparam int NDI = 3;
  localparam int NDF = 22;
  localparam int LMX = 4;
  localparam int DW  = NDI + NDF;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     dv_in = 1'b0;
  logic signed [NDI-1:-NDF] d_in = '0;
  logic [2:0]               ratio_log2 = '0;
  logic                     mode = 1'b0;
  logic                     dv_out;
  logic signed [NDI-1:-NDF] d_out;
`ifdef IIR_DECIM_SYNC_EN
  logic                     sync_in = 1'b0;
`endif

  iir_decim #(.Ndint(NDI), .Ndfrac(NDF), .Lmax(LMX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef IIR_DECIM_SYNC_EN
    .sync_in    (sync_in),
`endif
    .dv_in      (dv_in),
    .d_in       (d_in),
    .ratio_log2 (ratio_log2),
    .mode       (mode),
    .dv_out     (dv_out),
    .d_out      (d_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    data_t val;
    int    due;
    string name;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: every dv_out must match the oldest expectation in value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: no dv_out at cycle %0d, required value %0d", e.name, e.due, e.val);
    end
    if (dv_out) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_dv_out: cycle %0d d_out=%0d, required no strobe", cyc, d_out);
      end else begin
        e = sbq.pop_front();
        if (e.due != cyc || d_out !== e.val) begin
          n_fail++;
          $display("FAIL %s: got d_out=%0d at cycle %0d, required %0d at cycle %0d",
                   e.name, d_out, cyc, e.val, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Drive one sample for one cycle; optionally expect an output one cycle later.
  task automatic send(input int v, input bit expect_out, input int exp_v, input string nm);
    dv_in = 1'b1;
    d_in  = DW'(v);
    if (expect_out) sbq.push_back('{val: data_t'(exp_v), due: cyc + 1, name: nm});
    @(posedge clk);
    #1;
    dv_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("reset_dv_out", int'(dv_out), 0);
    chk("reset_d_out", int'(d_out), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Average R=4, gapped input like iir_sos output
    mode = 1'b1; ratio_log2 = 3'd2;
    for (int i = 0; i < 4; i++) begin
      send(4194304, i == 3, 4194304, "avg_r4_gapped");
      if (i < 3) idle(6);
    end
    idle(3);

    // Pick R=8, back-to-back ramp
    mode = 1'b0; ratio_log2 = 3'd3;
    for (int i = 0; i < 16; i++) begin
      send(i, (i == 7) || (i == 15), (i == 7) ? 0 : 8, "pick_r8_ramp");
    end
    idle(3);

    // Rounding, average R=2
    mode = 1'b1; ratio_log2 = 3'd1;
    send(1, 1'b0, 0, "");  send(2, 1'b1, 2, "round_1_2");
    send(-1, 1'b0, 0, ""); send(-2, 1'b1, -1, "round_m1_m2");
    send(1, 1'b0, 0, "");  send(0, 1'b1, 1, "round_1_0");
    idle(3);

    // Ratio change mid-group is ignored until the next group start
    ratio_log2 = 3'd2;
    send(4, 1'b0, 0, ""); send(4, 1'b0, 0, "");
    ratio_log2 = 3'd0;
    send(4, 1'b0, 0, ""); send(4, 1'b1, 4, "ratio_change_group");
    idle(2);
    send(7, 1'b1, 7, "ratio_change_passthru");
    idle(3);

    // R=1 back-to-back: continuous dv_out
    for (int i = 0; i < 4; i++) send(-3 * i + 11, 1'b1, -3 * i + 11, "r1_back_to_back");
    idle(3);

    // Reset mid-group discards the partial group
    ratio_log2 = 3'd2;
    send(100, 1'b0, 0, ""); send(100, 1'b0, 0, "");
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_dv_out", int'(dv_out), 0);
    chk("midreset_d_out", int'(d_out), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send(2097152, i == 3, 2097152, "after_reset_avg");
    idle(3);

    // Full-scale negative, average R=16
    ratio_log2 = 3'd4;
    for (int i = 0; i < 16; i++) send(-16777216, i == 15, -16777216, "fullscale_r16");
    idle(3);

    // ratio_log2 above Lmax clamps to Lmax; mode change mid-group ignored
    mode = 1'b0; ratio_log2 = 3'd7;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) mode = 1'b1;
      send(i + 5, i == 15, 5, "clamp_pick_r16");
    end
    idle(3);

`ifdef IIR_DECIM_SYNC_EN
    // sync_in alone drops the partial group; 16 further samples complete one
    mode = 1'b1; ratio_log2 = 3'd4;
    for (int i = 0; i < 4; i++) send(-16777216, 1'b0, 0, "");
    sync_in = 1'b1;
    @(posedge clk);
    #1;
    sync_in = 1'b0;
    for (int i = 0; i < 16; i++) send(-16777216, i == 15, -16777216, "sync_fullscale_r16");
    idle(3);

    // sync_in with dv_in: that sample is sample 0 of a new group
    ratio_log2 = 3'd1;
    send(10, 1'b0, 0, "");
    sync_in = 1'b1;
    send(6, 1'b0, 0, "");
    sync_in = 1'b0;
    send(4, 1'b1, 5, "sync_with_dv");
    idle(3);
`endif

    idle(4);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
